// File: rtl/count_sequencer.sv
// count_sequencer: latches a terminal count and prescale ratio, then steps q from 0 to the limit
// with pause, stop, auto-reload and a start/busy/done handshake.
module count_sequencer #(
  parameter int WIDTH = 4,
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] limit,
  input  logic [PSC_W-1:0] prescale,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10, DONE = 2'b11} state_t;
  state_t cur, nxt;
  logic [WIDTH-1:0] limit_r;
  logic [PSC_W-1:0] psc_r, psc_cnt;
  logic go, step, wrap, last;
  assign go   = start && (cur == IDLE || (cur == DONE && !stop));
  assign step = cur == RUN && !stop && !pause && psc_cnt == psc_r;
  assign wrap = q == limit_r;
  assign last = (q + WIDTH'(1)) == limit_r;
  always_ff @(posedge clk or posedge reset)
    if (reset) cur <= IDLE;
    else cur <= nxt;
  always_comb begin
    nxt = cur;
    if (go) nxt = (limit == '0) ? DONE : RUN;
    else if (stop && cur != IDLE) nxt = IDLE;
    else if (cur == RUN) nxt = pause ? HOLD : (step && !wrap && last && !auto_reload) ? DONE : RUN;
    else if (cur == HOLD && !pause) nxt = RUN;
  end
  always_comb begin
    busy  = cur == RUN || cur == HOLD;
    state = cur;
  end
  // HOLD and the HOLD->RUN edge leave the datapath untouched, so a release resumes mid-prescale
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q       <= '0;
      tick    <= 1'b0;
      done    <= 1'b0;
      limit_r <= '0;
      psc_r   <= '0;
      psc_cnt <= '0;
    end else begin
      tick <= step;
      done <= (step && !wrap && last) || (go && limit == '0);
      if (go) begin
        limit_r <= limit;
        psc_r   <= prescale;
        q       <= '0;
        psc_cnt <= '0;
      end else if (stop && cur != IDLE) begin
        q       <= '0;
        psc_cnt <= '0;
      end else if (step) begin
        psc_cnt <= '0;
        q       <= wrap ? '0 : q + WIDTH'(1);
      end else if (cur == RUN && !pause) psc_cnt <= psc_cnt + PSC_W'(1);
    end
endmodule
